// File: rtl/axi_burst_addr_gen_if.sv
// Request/beat bundle for axi_burst_addr_gen: AxID/AxADDR/AxLEN/AxSIZE/AxBURST in, per-beat info out.
// slave = generator side, master = requester/consumer side.
interface axi_burst_addr_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [2:0]        req_size;
    logic [1:0]        req_burst;

    logic              beat_valid;
    logic              beat_ready;
    logic [ID_W-1:0]   beat_id;
    logic [ADDR_W-1:0] beat_addr;
    logic [NB-1:0]     beat_strb;
    logic [LEN_W-1:0]  beat_idx;
    logic              beat_last;
    logic              beat_err;

    modport slave (
        input  req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
        output req_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err
    );

    modport master (
        output req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
        input  req_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI4 address request into per-beat addr/strb/idx/last/err (FIXED/INCR/WRAP); AXI_4K_CHECK_EN adds 4 KB-crossing err.
// Latency: first beat the cycle after the request handshake, then one beat per cycle; zero bubble between bursts.
// Backpressure: beat outputs hold while beat_ready is low; req_ready only in IDLE or on the last-beat handshake.
module axi_burst_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8
) (
    input logic                 ACLK,
    input logic                 ARESETn,
    axi_burst_addr_gen_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int LB  = $clog2(NB);
    localparam int LBW = (LB == 0) ? 1 : LB;
    localparam int LW1 = LBW + 1;

    localparam logic [1:0] BT_FIXED = 2'b00;
    localparam logic [1:0] BT_INCR  = 2'b01;
    localparam logic [1:0] BT_WRAP  = 2'b10;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     strb_q;
    logic [LEN_W-1:0]  idx_q;
    logic              last_q;
    logic              err_q;
    logic [LEN_W-1:0]  len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [ADDR_W-1:0] wmask_q;

    // Lanes from the address offset up to the end of the B-aligned container holding it.
    function automatic logic [NB-1:0] strb_of(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
        logic [LW1-1:0] lo;
        logic [LW1-1:0] hi;
        logic [LW1-1:0] bm1;
        strb_of = '0;
        bm1 = LW1'((1 << sz) - 1);
        lo  = {1'b0, a[LBW-1:0] & LBW'(NB - 1)};
        hi  = (lo & ~bm1) + bm1;
        for (int i = 0; i < NB; i++)
            strb_of[i] = (LW1'(i) >= lo) && (LW1'(i) <= hi);
    endfunction

    logic [2:0]        size_c;
    logic [ADDR_W-1:0] bmask_c;
    logic [ADDR_W-1:0] wmask_c;
    logic              wrap_ok;
    logic              err_c;
    logic [1:0]        burst_c;
`ifdef AXI_4K_CHECK_EN
    logic [ADDR_W-1:0] end_c;
`endif

    always_comb begin
        size_c  = (bus.req_size > 3'(LB)) ? 3'(LB) : bus.req_size;
        bmask_c = (ADDR_W'(1) << size_c) - ADDR_W'(1);
        // (len+1)*B - 1: wrap window mask, and also the byte span of an INCR burst minus one
        wmask_c = ((ADDR_W'(bus.req_len) + ADDR_W'(1)) << size_c) - ADDR_W'(1);
        wrap_ok = ((bus.req_len == LEN_W'(1)) || (bus.req_len == LEN_W'(3)) ||
                   (bus.req_len == LEN_W'(7)) || (bus.req_len == LEN_W'(15))) &&
                  ((bus.req_addr & bmask_c) == '0);
        err_c   = (bus.req_size > 3'(LB));
        burst_c = BT_INCR;
        case (bus.req_burst)
            BT_FIXED: burst_c = BT_FIXED;
            BT_INCR:  burst_c = BT_INCR;
            BT_WRAP: begin
                if (wrap_ok) burst_c = BT_WRAP;
                else         err_c   = 1'b1;
            end
            default:  err_c = 1'b1;
        endcase
`ifdef AXI_4K_CHECK_EN
        end_c = (bus.req_addr & ~bmask_c) + wmask_c;
        if ((burst_c == BT_INCR) && (end_c[ADDR_W-1:12] != bus.req_addr[ADDR_W-1:12]))
            err_c = 1'b1;
`endif
    end

    logic [ADDR_W-1:0] b_n;
    logic [ADDR_W-1:0] nxt_addr;

    always_comb begin
        b_n = ADDR_W'(1) << size_q;
        case (burst_q)
            BT_FIXED: nxt_addr = addr_q;
            BT_WRAP:  nxt_addr = (addr_q & ~wmask_q) | ((addr_q + b_n) & wmask_q);
            default:  nxt_addr = (addr_q & ~(b_n - ADDR_W'(1))) + b_n;
        endcase
    end

    logic beat_fire;
    logic req_rdy;
    logic req_fire;

    assign beat_fire = (state == BURST) & bus.beat_ready;
    assign req_rdy   = (state == IDLE) | (beat_fire & last_q);
    assign req_fire  = bus.req_valid & req_rdy;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            strb_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BT_FIXED;
            wmask_q <= '0;
        end else if (req_fire) begin
            state   <= BURST;
            id_q    <= bus.req_id;
            addr_q  <= bus.req_addr;
            strb_q  <= strb_of(bus.req_addr, size_c);
            idx_q   <= '0;
            last_q  <= (bus.req_len == '0);
            err_q   <= err_c;
            len_q   <= bus.req_len;
            size_q  <= size_c;
            burst_q <= burst_c;
            wmask_q <= wmask_c;
        end else if (beat_fire) begin
            if (last_q) begin
                state  <= IDLE;
                last_q <= 1'b0;
            end else begin
                addr_q <= nxt_addr;
                strb_q <= strb_of(nxt_addr, size_q);
                idx_q  <= idx_q + LEN_W'(1);
                last_q <= ((idx_q + LEN_W'(1)) == len_q);
            end
        end
    end

    assign bus.req_ready  = req_rdy;
    assign bus.beat_valid = (state == BURST);
    assign bus.beat_id    = id_q;
    assign bus.beat_addr  = addr_q;
    assign bus.beat_strb  = strb_q;
    assign bus.beat_idx   = idx_q;
    assign bus.beat_last  = last_q;
    assign bus.beat_err   = err_q;
endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed bench for axi_burst_addr_gen (DATA_W=32): hand-computed beat tables per burst type and corner case.
module tb_axi_burst_addr_gen;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_burst_addr_gen_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(8)) bus ();

    axi_burst_addr_gen #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .LEN_W(8)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

`ifdef AXI_4K_CHECK_EN
    localparam logic ERR_4K = 1'b1;
`else
    localparam logic ERR_4K = 1'b0;
`endif

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] cur_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bt);
        bus.req_valid = 1'b1;
        bus.req_id    = id;
        bus.req_addr  = a;
        bus.req_len   = len;
        bus.req_size  = sz;
        bus.req_burst = bt;
    endtask

    // Called at a negedge in IDLE; returns at the negedge where beat 0 is visible.
    task automatic issue(input string tag, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
        drive_req(id, a, len, sz, bt);
        chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(1));
        @(negedge ACLK);
        bus.req_valid = 1'b0;
        cur_id = id;
    endtask

    // Checks the beat on display (beat_ready=1) and steps to the next negedge.
    task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] s, input logic [7:0] idx,
                        input logic l, input logic e);
        chk({tag, ".valid"}, 64'(bus.beat_valid), 64'(1));
        chk({tag, ".id"},    64'(bus.beat_id),    64'(cur_id));
        chk({tag, ".addr"},  64'(bus.beat_addr),  64'(a));
        chk({tag, ".strb"},  64'(bus.beat_strb),  64'(s));
        chk({tag, ".idx"},   64'(bus.beat_idx),   64'(idx));
        chk({tag, ".last"},  64'(bus.beat_last),  64'(l));
        chk({tag, ".err"},   64'(bus.beat_err),   64'(e));
        @(negedge ACLK);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".valid"},     64'(bus.beat_valid), 64'(0));
        chk({tag, ".req_ready"}, 64'(bus.req_ready),  64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cur_id = '0;
        bus.req_valid = 1'b0; bus.req_id = '0; bus.req_addr = '0; bus.req_len = '0;
        bus.req_size = '0; bus.req_burst = '0; bus.beat_ready = 1'b1;
        repeat (2) @(negedge ACLK);
        idle_chk("rst");
        chk("rst.addr", 64'(bus.beat_addr), 64'(0));
        chk("rst.strb", 64'(bus.beat_strb), 64'(0));
        chk("rst.idx",  64'(bus.beat_idx),  64'(0));
        chk("rst.id",   64'(bus.beat_id),   64'(0));
        chk("rst.last", 64'(bus.beat_last), 64'(0));
        chk("rst.err",  64'(bus.beat_err),  64'(0));
        ARESETn = 1'b1;
        @(negedge ACLK);

        issue("incr", 4'h1, 32'h1002, 8'd3, 3'd2, INCR);
        beat("incr0", 32'h1002, 4'b1100, 8'd0, 1'b0, 1'b0);
        beat("incr1", 32'h1004, 4'b1111, 8'd1, 1'b0, 1'b0);
        beat("incr2", 32'h1008, 4'b1111, 8'd2, 1'b0, 1'b0);
        beat("incr3", 32'h100C, 4'b1111, 8'd3, 1'b1, 1'b0);
        idle_chk("incr_end");

        issue("wrap", 4'h2, 32'h1034, 8'd3, 3'd2, WRAP);
        beat("wrap0", 32'h1034, 4'b1111, 8'd0, 1'b0, 1'b0);
        beat("wrap1", 32'h1038, 4'b1111, 8'd1, 1'b0, 1'b0);
        beat("wrap2", 32'h103C, 4'b1111, 8'd2, 1'b0, 1'b0);
        beat("wrap3", 32'h1030, 4'b1111, 8'd3, 1'b1, 1'b0);
        idle_chk("wrap_end");

        issue("fixed", 4'h3, 32'h2001, 8'd2, 3'd0, FIXED);
        beat("fix0", 32'h2001, 4'b0010, 8'd0, 1'b0, 1'b0);
        beat("fix1", 32'h2001, 4'b0010, 8'd1, 1'b0, 1'b0);
        beat("fix2", 32'h2001, 4'b0010, 8'd2, 1'b1, 1'b0);

        // Illegal WRAP length runs as INCR with err
        issue("wrapbad", 4'h4, 32'h2000, 8'd2, 3'd2, WRAP);
        beat("wbad0", 32'h2000, 4'b1111, 8'd0, 1'b0, 1'b1);
        beat("wbad1", 32'h2004, 4'b1111, 8'd1, 1'b0, 1'b1);
        beat("wbad2", 32'h2008, 4'b1111, 8'd2, 1'b1, 1'b1);

        issue("size", 4'h5, 32'h3000, 8'd1, 3'd3, INCR);
        beat("sz0", 32'h3000, 4'b1111, 8'd0, 1'b0, 1'b1);
        beat("sz1", 32'h3004, 4'b1111, 8'd1, 1'b1, 1'b1);

        issue("rsvd", 4'h6, 32'h4001, 8'd1, 3'd0, RSVD);
        beat("rsv0", 32'h4001, 4'b0010, 8'd0, 1'b0, 1'b1);
        beat("rsv1", 32'h4002, 4'b0100, 8'd1, 1'b1, 1'b1);

        issue("half", 4'h7, 32'h5003, 8'd1, 3'd1, INCR);
        beat("hw0", 32'h5003, 4'b1000, 8'd0, 1'b0, 1'b0);
        beat("hw1", 32'h5004, 4'b0011, 8'd1, 1'b1, 1'b0);

        issue("page", 4'h8, 32'h0FF8, 8'd3, 3'd2, INCR);
        beat("pg0", 32'h0FF8, 4'b1111, 8'd0, 1'b0, ERR_4K);
        beat("pg1", 32'h0FFC, 4'b1111, 8'd1, 1'b0, ERR_4K);
        beat("pg2", 32'h1000, 4'b1111, 8'd2, 1'b0, ERR_4K);
        beat("pg3", 32'h1004, 4'b1111, 8'd3, 1'b1, ERR_4K);
        idle_chk("page_end");

        // Backpressure at idx 1, then a new request on the last-beat handshake
        issue("bp", 4'h9, 32'h6000, 8'd2, 3'd2, INCR);
        beat("bp0", 32'h6000, 4'b1111, 8'd0, 1'b0, 1'b0);
        bus.beat_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("stall.valid", 64'(bus.beat_valid), 64'(1));
            chk("stall.addr",  64'(bus.beat_addr),  64'(32'h6004));
            chk("stall.idx",   64'(bus.beat_idx),   64'(1));
            chk("stall.strb",  64'(bus.beat_strb),  64'(4'b1111));
            chk("stall.last",  64'(bus.beat_last),  64'(0));
            chk("stall.rdy",   64'(bus.req_ready),  64'(0));
        end
        bus.beat_ready = 1'b1;
        beat("bp1", 32'h6004, 4'b1111, 8'd1, 1'b0, 1'b0);
        drive_req(4'hA, 32'h7000, 8'd0, 3'd2, INCR);
        chk("b2b.req_ready", 64'(bus.req_ready), 64'(1));
        beat("bp2", 32'h6008, 4'b1111, 8'd2, 1'b1, 1'b0);
        bus.req_valid = 1'b0;
        cur_id = 4'hA;
        beat("b2b0", 32'h7000, 4'b1111, 8'd0, 1'b1, 1'b0);
        idle_chk("b2b_end");

        // Reset in the middle of a long burst
        issue("arst", 4'hB, 32'h8000, 8'd7, 3'd2, INCR);
        beat("ar0", 32'h8000, 4'b1111, 8'd0, 1'b0, 1'b0);
        beat("ar1", 32'h8004, 4'b1111, 8'd1, 1'b0, 1'b0);
        chk("ar2.idx", 64'(bus.beat_idx), 64'(2));
        ARESETn = 1'b0;
        #1;
        idle_chk("arst_now");
        chk("arst_now.idx",  64'(bus.beat_idx),  64'(0));
        chk("arst_now.addr", 64'(bus.beat_addr), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            idle_chk("arst_after");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
